// File: rtl/nibble_serial_tx.sv
// FIFO-buffered nibble serializer: start, 4 data bits MSB-first, optional even parity, stop.
// Define NIBBLE_TX_PARITY_EN to insert the parity bit between DATA[0] and STOP.
module nibble_serial_tx #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef NIBBLE_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    bit_q, bit_d;
    logic [3:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          push, pop, bit_last;
`ifdef NIBBLE_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign in_ready   = (count_q != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign bit_last   = (timer_q == T_LAST);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_last;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // tx_d always carries the line level belonging to state_d, so tx stays registered.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef NIBBLE_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != S_IDLE) begin
            timer_d = bit_last ? '0 : timer_q + TW'(1);
        end
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                    bit_d   = 2'd3;
                    tx_d    = shift_q[3];
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    if (bit_q == 2'd0) begin
`ifdef NIBBLE_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q - 2'd1;
                        shift_d = {shift_q[2:0], 1'b0};
                        tx_d    = shift_q[2];
                    end
                end
            end
`ifdef NIBBLE_TX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef NIBBLE_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef NIBBLE_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench: two transmitters (1 and 3 clocks per bit) share one input stream;
// each has a frame-level reference model that decodes its serial line against accepted words.
module tb_nibble_serial_tx;
    localparam int DEPTH = 4;
    localparam int NI    = 2;
`ifdef NIBBLE_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] in_data  = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready_w   [NI];
    logic       tx_w         [NI];
    logic       busy_w       [NI];
    logic       frame_done_w [NI];
    logic [2:0] fifo_count_w [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", name, inst, $time, act, req);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int CPB = (gi == 0) ? 1 : 3;

        logic [3:0] exp_q [$];
        logic       rst_edge = 1'b0;

        nibble_serial_tx #(
            .DEPTH(DEPTH),
            .CLKS_PER_BIT(CPB)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_data(in_data),
            .in_valid(in_valid),
            .in_ready(in_ready_w[gi]),
            .tx(tx_w[gi]),
            .busy(busy_w[gi]),
            .frame_done(frame_done_w[gi]),
            .fifo_count(fifo_count_w[gi])
        );

        always @(posedge clk) rst_edge <= rst;

        initial begin : monitor
            int          cnt;
            int          pos;
            logic        push_prev;
            logic [3:0]  push_data;
            logic        active;
            logic        expect_start;
            logic [NB-1:0] fb;
            logic [3:0]  w;
            cnt = 0; pos = 0; push_prev = 1'b0; push_data = 4'h0;
            active = 1'b0; expect_start = 1'b0; fb = '1; w = 4'h0;
            forever begin
                @(negedge clk);
                if (rst_edge) begin
                    cnt = 0; active = 1'b0; expect_start = 1'b0; push_prev = 1'b0;
                    exp_q.delete();
                    chk("rst_tx", gi, 32'(tx_w[gi]), 32'd1);
                    chk("rst_busy", gi, 32'(busy_w[gi]), 32'd0);
                    chk("rst_count", gi, 32'(fifo_count_w[gi]), 32'd0);
                    chk("rst_ready", gi, 32'(in_ready_w[gi]), 32'd1);
                    chk("rst_done", gi, 32'(frame_done_w[gi]), 32'd0);
                end else begin
                    if (push_prev) begin
                        cnt++;
                        exp_q.push_back(push_data);
                    end
                    if (active) begin
                        chk("tx_bit", gi, 32'(tx_w[gi]), 32'(fb[NB-1-pos/CPB]));
                        chk("busy_frame", gi, 32'(busy_w[gi]), 32'd1);
                        chk("frame_done", gi, 32'(frame_done_w[gi]), 32'(pos == NB*CPB-1));
                        pos++;
                        if (pos == NB*CPB) active = 1'b0;
                        expect_start = 1'b0;
                    end else if (tx_w[gi] == 1'b0) begin
                        chk("start_expected", gi, 32'(expect_start), 32'd1);
                        chk("busy_start", gi, 32'(busy_w[gi]), 32'd1);
                        chk("done_start", gi, 32'(frame_done_w[gi]), 32'd0);
                        expect_start = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("queue_nonempty", gi, 32'd0, 32'd1);
                        end else begin
                            w = exp_q.pop_front();
                            cnt--;
`ifdef NIBBLE_TX_PARITY_EN
                            fb = {1'b0, w, ^w, 1'b1};
`else
                            fb = {1'b0, w, 1'b1};
`endif
                            active = 1'b1;
                            pos = 1;
                            if (pos == NB*CPB) active = 1'b0;
                            $display("inst%0d frame word=%h t=%0t", gi, w, $time);
                        end
                    end else begin
                        chk("idle_gap", gi, 32'(expect_start), 32'd0);
                        chk("busy_idle", gi, 32'(busy_w[gi]), 32'd0);
                        chk("done_idle", gi, 32'(frame_done_w[gi]), 32'd0);
                        expect_start = (cnt > 0);
                    end
                    chk("fifo_count", gi, 32'(fifo_count_w[gi]), 32'(cnt));
                    chk("in_ready", gi, 32'(in_ready_w[gi]), 32'(cnt < DEPTH));
                end
                push_prev = !rst && in_valid && (cnt < DEPTH);
                push_data = in_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        rst = 1'b1; in_valid = 1'b0;
        step(2);
        rst = 1'b0;
        step(10);

        in_data = 4'hA; in_valid = 1'b1; step(1);
        in_valid = 1'b0; step(25);

        in_data = 4'h7; in_valid = 1'b1; step(1);
        in_data = 4'h3; step(1);
        in_valid = 1'b0; step(45);

        // Words 1..5 held until the slow transmitter accepts each, so its FIFO fills.
        for (int v = 1; v <= 5; v++) begin
            in_data = 4'(v); in_valid = 1'b1;
            guard = 0;
            while (!in_ready_w[1] && guard < 200) begin
                step(1);
                guard++;
            end
            if (guard >= 200) chk("accept_timeout", 1, 32'd1, 32'd0);
            step(1);
        end
        in_valid = 1'b0;
        step(150);

        for (int i = 0; i < 120; i++) begin
            in_valid = ($urandom_range(0, 99) < 85);
            in_data  = 4'($urandom);
            step(1);
        end
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 99) < 30);
            in_data  = 4'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        step(150);

        // Reset in the middle of the slow transmitter's DATA bit 2 with two words queued.
        in_data = 4'hF; in_valid = 1'b1; step(1);
        in_data = 4'($urandom); step(1);
        in_data = 4'($urandom); step(1);
        in_valid = 1'b0;
        guard = 0;
        while (tx_w[1] !== 1'b0 && guard < 50) begin
            step(1);
            guard++;
        end
        if (guard >= 50) chk("start_timeout", 1, 32'd1, 32'd0);
        step(3 * 2 + 1);
        rst = 1'b1; step(2);
        rst = 1'b0; step(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
